// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage constants and the next-PC source encoding.
package fetch_stage_pkg;

    localparam int unsigned PC_WIDTH  = 32;
    localparam logic [31:0] RESET_PC  = 32'hBFC0_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        PCSEL_SEQ,
        PCSEL_BR,
        PCSEL_JMP,
        PCSEL_FLUSH
    } pc_sel_e;

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// PC register with prioritised next-PC mux: flush > stall hold > jump > branch > sequential.
module pc_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_PC_VAL = RESET_PC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic [PC_WIDTH-1:0] flush_pc,
    input  logic                jump,
    input  logic [PC_WIDTH-1:0] jump_target,
    input  logic                branch,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic [PC_WIDTH-1:0] pc
);

    pc_sel_e             sel;
    logic [PC_WIDTH-1:0] pc_next;

    always_comb begin
        sel = PCSEL_SEQ;
        if (flush)
            sel = PCSEL_FLUSH;
        else if (jump)
            sel = PCSEL_JMP;
        else if (branch)
            sel = PCSEL_BR;
    end

    always_comb begin
        pc_next = pc + 32'd4;
        unique case (sel)
            PCSEL_FLUSH: pc_next = flush_pc;
            PCSEL_JMP:   pc_next = jump_target;
            PCSEL_BR:    pc_next = branch_target;
            default:     pc_next = pc + 32'd4;
        endcase
    end

    // Stall holds the PC and masks any redirect; only flush overrides it.
    always_ff @(posedge clk) begin
        if (rst)
            pc <= RESET_PC_VAL;
        else if (flush || !stall)
            pc <= pc_next;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives the synchronous instruction SRAM and the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = fetch_stage_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallD,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        branch_takenD,
    input  logic [31:0] branch_targetD,
    input  logic        jumpD,
    input  logic [31:0] jump_targetD,
    output logic        inst_sram_en,
    output logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_rdata,
    output logic [31:0] instrD,
    output logic [31:0] pcD,
    output logic        validD,
    output logic        adelF
);

    logic [31:0] pcF;
    logic [31:0] hold_instr;
    logic        hold_valid;
    logic        id_load;

    pc_reg #(
        .RESET_PC_VAL (RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .rst           (rst),
        .stall         (stallD),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .jump          (jumpD),
        .jump_target   (jump_targetD),
        .branch        (branch_takenD),
        .branch_target (branch_targetD),
        .pc            (pcF)
    );

    assign adelF          = (pcF[1:0] != 2'b00);
    assign inst_sram_en   = !rst && !stallD && !adelF;
    assign inst_sram_addr = pcF;
    assign id_load        = !stallD || flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            pcD    <= '0;
            validD <= 1'b0;
        end else if (id_load) begin
            pcD    <= pcF;
            validD <= !flush && !adelF;
        end
    end

    // SRAM data is only valid for one cycle, so capture it on the first stalled cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_instr <= '0;
        end else if (flush || !stallD) begin
            hold_valid <= 1'b0;
        end else if (!hold_valid) begin
            hold_valid <= 1'b1;
            hold_instr <= inst_sram_rdata;
        end
    end

    always_comb begin
        instrD = inst_sram_rdata;
        if (rst || !validD)
            instrD = NOP_INSTR;
        else if (hold_valid)
            instrD = hold_instr;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by randomized control traffic.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallD = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        branch_takenD = 1'b0;
    logic [31:0] branch_targetD = '0;
    logic        jumpD = 1'b0;
    logic [31:0] jump_targetD = '0;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;
    logic [31:0] instrD;
    logic [31:0] pcD;
    logic        validD;
    logic        adelF;

    int unsigned tests = 0;
    int unsigned fails = 0;

    // Reference state: the PC in IF, and the PC/validity of the slot in ID.
    logic [31:0] m_pcF = 32'hBFC0_0000;
    logic [31:0] m_pcD = '0;
    logic        m_validD = 1'b0;

    logic [31:0] snap_instr;
    logic [31:0] snap_pc;

    fetch_stage #(
        .RESET_PC  (32'hBFC0_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stallD          (stallD),
        .flush           (flush),
        .flush_pc        (flush_pc),
        .branch_takenD   (branch_takenD),
        .branch_targetD  (branch_targetD),
        .jumpD           (jumpD),
        .jump_targetD    (jump_targetD),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_rdata (inst_sram_rdata),
        .instrD          (instrD),
        .pcD             (pcD),
        .validD          (validD),
        .adelF           (adelF)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'hBFC0_0004)
            return 32'h3C01_1234;
        return {a[15:0] ^ 16'hA5A5, a[31:16] ^ 16'h1357};
    endfunction

    // Synchronous SRAM; garbage on unenabled cycles exposes any reliance on stale read data.
    always @(posedge clk) begin
        if (inst_sram_en)
            inst_sram_rdata <= mem_word(inst_sram_addr);
        else
            inst_sram_rdata <= $urandom;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        logic [31:0] nxt;
        if (rst) begin
            m_pcF    = 32'hBFC0_0000;
            m_pcD    = '0;
            m_validD = 1'b0;
        end else begin
            if (flush)              nxt = flush_pc;
            else if (stallD)        nxt = m_pcF;
            else if (jumpD)         nxt = jump_targetD;
            else if (branch_takenD) nxt = branch_targetD;
            else                    nxt = m_pcF + 32'd4;
            if (!stallD || flush) begin
                m_pcD    = m_pcF;
                m_validD = !flush && (m_pcF[1:0] == 2'b00);
            end
            m_pcF = nxt;
        end
    endtask

    // One cycle: advance the model on the clock edge, apply new inputs, check all outputs.
    task automatic drive(input logic r, input logic s, input logic f, input logic [31:0] fpc,
                         input logic j, input logic [31:0] jt, input logic b, input logic [31:0] bt);
        logic        e_adel;
        logic [31:0] e_instr;
        @(posedge clk);
        model_update();
        @(negedge clk);
        rst = r; stallD = s; flush = f; flush_pc = fpc;
        jumpD = j; jump_targetD = jt; branch_takenD = b; branch_targetD = bt;
        #1;
        e_adel  = (m_pcF[1:0] != 2'b00);
        e_instr = (rst || !m_validD) ? 32'h0 : mem_word(m_pcD);
        chk("addr",   inst_sram_addr, m_pcF);
        chk("adelF",  {31'b0, adelF}, {31'b0, e_adel});
        chk("en",     {31'b0, inst_sram_en}, {31'b0, !rst && !stallD && !e_adel});
        chk("pcD",    pcD, m_pcD);
        chk("validD", {31'b0, validD}, {31'b0, m_validD});
        chk("instrD", instrD, e_instr);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    initial begin
        // T1: reset for three cycles, then release
        repeat (3) drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        chk("T1 rst en", {31'b0, inst_sram_en}, 32'h0);
        chk("T1 rst instrD", instrD, 32'h0);
        idle();
        chk("T1 addr0", inst_sram_addr, 32'hBFC0_0000);
        idle();
        chk("T1 pcD0", pcD, 32'hBFC0_0000);
        chk("T1 valid0", {31'b0, validD}, 32'h1);
        chk("T1 addr1", inst_sram_addr, 32'hBFC0_0004);

        // T2: three-cycle stall holding 0x3C011234 in ID
        drive(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        chk("T2 instr", instrD, 32'h3C01_1234);
        chk("T2 en", {31'b0, inst_sram_en}, 32'h0);
        snap_instr = instrD;
        snap_pc    = pcD;
        repeat (2) begin
            drive(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
            chk("T2 hold instr", instrD, snap_instr);
            chk("T2 hold pcD", pcD, snap_pc);
        end
        // T3: branch resolved on the first cycle after the stall
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 32'hBFC0_0100);
        chk("T2 release instr", instrD, snap_instr);
        chk("T2 release pcD", pcD, snap_pc);
        chk("T2 resume addr", inst_sram_addr, 32'hBFC0_0008);
        idle();
        chk("T3 slot pcD", pcD, 32'hBFC0_0008);
        chk("T3 slot valid", {31'b0, validD}, 32'h1);
        chk("T3 target", inst_sram_addr, 32'hBFC0_0100);

        // T4: flush during stall
        drive(1'b0, 1'b1, 1'b1, 32'hBFC0_0380, 1'b0, '0, 1'b0, '0);
        // T5: jump and branch together, then again under stall
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h8000_0000, 1'b1, 32'hBFC0_0200);
        chk("T4 valid", {31'b0, validD}, 32'h0);
        chk("T4 instr", instrD, 32'h0);
        chk("T4 addr", inst_sram_addr, 32'hBFC0_0380);
        drive(1'b0, 1'b1, 1'b0, '0, 1'b1, 32'h9000_0000, 1'b1, 32'hBFC0_0200);
        chk("T5 jump wins", inst_sram_addr, 32'h8000_0000);
        idle();
        chk("T5 stall hold", inst_sram_addr, 32'h8000_0000);

        // T6: misaligned jump target
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'hBFC0_0002, 1'b0, '0);
        idle();
        chk("T6 adel", {31'b0, adelF}, 32'h1);
        chk("T6 en", {31'b0, inst_sram_en}, 32'h0);
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'hBFC0_0010, 1'b0, '0);
        chk("T6 slot valid", {31'b0, validD}, 32'h0);
        chk("T6 slot pcD", pcD, 32'hBFC0_0002);
        idle();
        chk("T6 recover", {31'b0, adelF}, 32'h0);

        // Randomized control traffic
        for (int i = 0; i < 400; i++) begin
            logic        r, s, f, j, b;
            logic [31:0] fpc, jt, bt;
            r   = ($urandom_range(0, 39) == 0);
            s   = ($urandom_range(0, 3) == 0);
            f   = ($urandom_range(0, 11) == 0);
            j   = ($urandom_range(0, 7) == 0);
            b   = ($urandom_range(0, 5) == 0);
            fpc = $urandom & 32'hFFFF_FFFC;
            jt  = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            bt  = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            drive(r, s, f, fpc, j, jt, b, bt);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
